keccak_host_sequencer: RTL and testbench

Upstream driver for the Keccak Avalon-MM slave component. Accepts message words on a valid/ready stream and issues the slave's register protocol: length/flag write, data write, status polling, hash_ready clear, and digest readout. Returns the 8-word digest on a valid/ready output stream, so a hash can be requested without a CPU on the Avalon bus.

---
 rtl/keccak_host_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_keccak_host_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_host_sequencer.sv
// Host-side sequencer for the Keccak Avalon-MM slave: streams message words in, digest words out.
// Define KECCAK_SEQ_TIMEOUT_EN to abort a hash after POLL_LIMIT unsuccessful status reads.
module keccak_host_sequencer #(
    parameter int DIGEST_WORDS  = 8,
    parameter int POLL_INTERVAL = 16,
    parameter int POLL_LIMIT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] msg_data,
    input  logic [5:0]  msg_bits,
    input  logic        msg_last,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [4:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic        avm_write,
    output logic        avm_read,
    output logic        avm_chipselect,
    input  logic [31:0] avm_readdata,
    output logic [31:0] dig_data,
    output logic [2:0]  dig_index,
    output logic        dig_last,
    output logic        dig_valid,
    input  logic        dig_ready,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        IDLE, WR_LEN, GAP1, WR_DATA, GAP2, POLL_WAIT, POLL_RD, POLL_CAP,
        CLR, GAP3, DIG_RD, DIG_CAP, DIG_OUT
    } state_t;

    localparam int                WAIT_W      = $clog2(POLL_INTERVAL + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(POLL_INTERVAL - 1);
    localparam logic [2:0]        IDX_LAST    = 3'(DIGEST_WORDS - 1);
    localparam logic [4:0]        ADDR_LEN    = 5'h00;
    localparam logic [4:0]        ADDR_DATA   = 5'h01;
    localparam logic [4:0]        ADDR_STATUS = 5'h04;
    localparam logic [4:0]        ADDR_DIGEST = 5'h10;

    state_t            state;
    logic [31:0]       data_q;
    logic              last_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        idx;

`ifdef KECCAK_SEQ_TIMEOUT_EN
    localparam int                POLL_W   = $clog2(POLL_LIMIT + 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);
    logic [POLL_W-1:0] poll_cnt;
    logic              timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // The slave accepts at most 32 valid bits per data word.
    function automatic logic [31:0] len_word(input logic [5:0] bits, input logic last);
        logic [5:0] clamped;
        clamped = (bits > 6'd32) ? 6'd32 : bits;
        return {last, 25'd0, clamped};
    endfunction

    always_ff @(posedge clk) begin
        if (state == IDLE && msg_valid && msg_ready) begin
            data_q <= msg_data;
            last_q <= msg_last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            msg_ready      <= 1'b0;
            busy           <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            dig_data       <= '0;
            dig_index      <= '0;
            dig_last       <= 1'b0;
            dig_valid      <= 1'b0;
            wait_cnt       <= '0;
            idx            <= '0;
`ifdef KECCAK_SEQ_TIMEOUT_EN
            poll_cnt       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; only the transitions below raise them.
            avm_byteenable <= 4'hF;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            case (state)
                IDLE: begin
                    if (msg_valid && msg_ready) begin
                        state          <= WR_LEN;
                        msg_ready      <= 1'b0;
                        busy           <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_LEN;
                        avm_writedata  <= len_word(msg_bits, msg_last);
                    end else begin
                        msg_ready <= 1'b1;
                    end
                end
                WR_LEN: state <= GAP1;
                GAP1: begin
                    state          <= WR_DATA;
                    avm_write      <= 1'b1;
                    avm_chipselect <= 1'b1;
                    avm_address    <= ADDR_DATA;
                    avm_writedata  <= data_q;
                end
                WR_DATA: state <= GAP2;
                GAP2: begin
                    if (last_q) begin
                        state    <= POLL_WAIT;
                        wait_cnt <= '0;
`ifdef KECCAK_SEQ_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                    end else begin
                        state     <= IDLE;
                        msg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                POLL_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state          <= POLL_RD;
                        avm_read       <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_STATUS;
`ifdef KECCAK_SEQ_TIMEOUT_EN
                        poll_cnt       <= poll_cnt + 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                POLL_RD: state <= POLL_CAP;
                // Read data returns one cycle after the strobe, i.e. during this state.
                POLL_CAP: begin
                    if (avm_readdata[0]) begin
                        state          <= CLR;
                        avm_write      <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_STATUS;
                        avm_writedata  <= '0;
                    end
`ifdef KECCAK_SEQ_TIMEOUT_EN
                    else if (poll_cnt == POLL_MAX) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        msg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
`endif
                    else begin
                        state    <= POLL_WAIT;
                        wait_cnt <= '0;
                    end
                end
                CLR: state <= GAP3;
                GAP3: begin
                    state          <= DIG_RD;
                    avm_read       <= 1'b1;
                    avm_chipselect <= 1'b1;
                    avm_address    <= ADDR_DIGEST | {2'b00, idx};
                end
                DIG_RD: state <= DIG_CAP;
                DIG_CAP: begin
                    state     <= DIG_OUT;
                    dig_data  <= avm_readdata;
                    dig_index <= idx;
                    dig_last  <= (idx == IDX_LAST);
                    dig_valid <= 1'b1;
                end
                DIG_OUT: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        if (idx == IDX_LAST) begin
                            idx       <= '0;
                            state     <= IDLE;
                            msg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idx            <= idx + 3'd1;
                            state          <= DIG_RD;
                            avm_read       <= 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_address    <= ADDR_DIGEST | {2'b00, idx + 3'd1};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_host_sequencer.sv
// Directed bench for keccak_host_sequencer with a behavioural Avalon slave and digest logger.
module tb_keccak_host_sequencer;
    localparam int PI = 4;
    localparam int PL = 4;
`ifdef KECCAK_SEQ_TIMEOUT_EN
    localparam int RA1 = 3;
`else
    localparam int RA1 = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] msg_data;
    logic [5:0]  msg_bits;
    logic        msg_last, msg_valid, msg_ready;
    logic [4:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write, avm_read, avm_chipselect;
    logic [31:0] avm_readdata = '0;
    logic [31:0] dig_data;
    logic [2:0]  dig_index;
    logic        dig_last, dig_valid, dig_ready;
    logic        busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    keccak_host_sequencer #(.DIGEST_WORDS(8), .POLL_INTERVAL(PI), .POLL_LIMIT(PL)) dut (
        .clk(clk), .reset(reset),
        .msg_data(msg_data), .msg_bits(msg_bits), .msg_last(msg_last),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_write(avm_write), .avm_read(avm_read),
        .avm_chipselect(avm_chipselect), .avm_readdata(avm_readdata),
        .dig_data(dig_data), .dig_index(dig_index), .dig_last(dig_last),
        .dig_valid(dig_valid), .dig_ready(dig_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and bus/digest loggers, sampled mid-cycle.
    logic [4:0]  wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int          wr_cyc  [0:255];
    int          wr_n = 0;
    logic [4:0]  rd_addr [0:255];
    int          rd_cyc  [0:255];
    int          rd_n = 0;
    logic [31:0] dg_data [0:63];
    logic [2:0]  dg_idx  [0:63];
    logic        dg_last [0:63];
    int          dg_n = 0;
    int          st_reads = 0;
    int          ready_after = 0;
    logic        hash_ready = 1'b0;
    logic        prev_strobe = 1'b0;
    int          gap_err = 0;
    int          cs_err = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_write && wr_n < 256) begin
                wr_addr[wr_n] = avm_address;
                wr_data[wr_n] = avm_writedata;
                wr_cyc[wr_n]  = cyc;
                wr_n++;
                if (avm_address == 5'h04 && avm_writedata == 32'h0) hash_ready = 1'b0;
                if (avm_address == 5'h00) st_reads = 0;
            end
            if (avm_read && rd_n < 256) begin
                rd_addr[rd_n] = avm_address;
                rd_cyc[rd_n]  = cyc;
                rd_n++;
                if (avm_address == 5'h04) begin
                    st_reads++;
                    if (ready_after != 0 && st_reads >= ready_after) hash_ready = 1'b1;
                    avm_readdata = {31'd0, hash_ready};
                end else begin
                    avm_readdata = 32'hD16E_0000 | {27'd0, avm_address};
                end
            end
            if (avm_chipselect !== (avm_write | avm_read)) cs_err++;
            if ((avm_write | avm_read) && avm_byteenable !== 4'hF) cs_err++;
            if ((avm_write | avm_read) && prev_strobe) gap_err++;
            prev_strobe = avm_write | avm_read;
            if (dig_valid && dig_ready && dg_n < 64) begin
                dg_data[dg_n] = dig_data;
                dg_idx[dg_n]  = dig_index;
                dg_last[dg_n] = dig_last;
                dg_n++;
            end
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] b, input logic l, output int acc);
        int k;
        msg_data  = d;
        msg_bits  = b;
        msg_last  = l;
        msg_valid = 1'b1;
        k = 0;
        while (!msg_ready && k < 300) begin
            tick();
            k++;
        end
        check("accept_ready", {31'd0, msg_ready}, 32'd1);
        tick();
        acc = cyc;
        msg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int dg_target);
        int k;
        k = 0;
        while (!(dg_n >= dg_target && !busy) && k < 3000) begin
            tick();
            k++;
        end
        check(tag, {31'd0, (dg_n >= dg_target && !busy)}, 32'd1);
    endtask

    task automatic check_digest(input string tag, input int db);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_data"}, dg_data[db+i], 32'hD16E_0010 + i);
            check({tag, "_idx"}, {29'd0, dg_idx[db+i]}, i);
            check({tag, "_last"}, {31'd0, dg_last[db+i]}, (i == 7) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, wb, rb, db, rn, r;
        int k;
        reset = 1'b1;
        msg_data = '0; msg_bits = '0; msg_last = 1'b0; msg_valid = 1'b0;
        dig_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_msg_ready", {31'd0, msg_ready}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_strobes", {29'd0, avm_write, avm_read, avm_chipselect}, 0);
        check("rst_be", {28'd0, avm_byteenable}, 0);
        check("rst_dig_valid", {31'd0, dig_valid}, 0);
        check("rst_timeout", {31'd0, timeout_err}, 0);
        reset = 1'b0;
        check("rel_msg_ready0", {31'd0, msg_ready}, 0);
        tick();
        check("rel_msg_ready1", {31'd0, msg_ready}, 1);

        // Single-word message, hash ready on poll RA1
        ready_after = RA1;
        wb = wr_n; rb = rd_n; db = dg_n;
        send(32'hCC00_0000, 6'd8, 1'b1, a);
        wait_done("t1_done", db + 8);
        check("t1_nwr", wr_n - wb, 3);
        check("t1_len_addr", {27'd0, wr_addr[wb]}, 32'h0);
        check("t1_len", wr_data[wb], 32'h8000_0008);
        check("t1_len_cyc", wr_cyc[wb], a);
        check("t1_dat_addr", {27'd0, wr_addr[wb+1]}, 32'h1);
        check("t1_dat", wr_data[wb+1], 32'hCC00_0000);
        check("t1_dat_cyc", wr_cyc[wb+1], a + 2);
        check("t1_clr_addr", {27'd0, wr_addr[wb+2]}, 32'h4);
        check("t1_clr", wr_data[wb+2], 32'h0);
        check("t1_nrd", rd_n - rb, RA1 + 8);
        check("t1_poll0_cyc", rd_cyc[rb], a + 4 + PI);
        check("t1_poll1_cyc", rd_cyc[rb+1], a + 6 + 2 * PI);
        for (int i = 0; i < RA1; i++) check("t1_poll_addr", {27'd0, rd_addr[rb+i]}, 32'h4);
        for (int i = 0; i < 8; i++) check("t1_dig_addr", {27'd0, rd_addr[rb+RA1+i]}, 32'h10 + i);
        check("t1_dig_rate", rd_cyc[rb+RA1+1] - rd_cyc[rb+RA1], 3);
        check("t1_ready_after", {31'd0, msg_ready}, 1);
        check_digest("t1", db);

        // Two full words, back to back
        ready_after = 2;
        wb = wr_n; db = dg_n;
        send(32'h1122_3344, 6'd32, 1'b0, a);
        for (int i = 0; i < 4; i++) begin
            check("t2_rdy_low1", {31'd0, msg_ready}, 0);
            tick();
        end
        check("t2_rdy_high1", {31'd0, msg_ready}, 1);
        send(32'h5566_7788, 6'd32, 1'b1, a2);
        check("t2_rate", a2 - a, 5);
        for (int i = 0; i < 4; i++) begin
            check("t2_rdy_low2", {31'd0, msg_ready}, 0);
            tick();
        end
        wait_done("t2_done", db + 8);
        check("t2_nwr", wr_n - wb, 5);
        check("t2_len1", wr_data[wb], 32'h0000_0020);
        check("t2_dat1", wr_data[wb+1], 32'h1122_3344);
        check("t2_len2", wr_data[wb+2], 32'h8000_0020);
        check("t2_dat2", wr_data[wb+3], 32'h5566_7788);
        check("t2_len2_cyc", wr_cyc[wb+2], a2);
        check("t2_clr_addr", {27'd0, wr_addr[wb+4]}, 32'h4);
        check_digest("t2", db);

        // Consumer stall on digest word 3
        ready_after = 1;
        db = dg_n;
        send(32'hA500_0000, 6'd8, 1'b1, a);
        k = 0;
        while (!(dig_valid && dig_index == 3'd2) && k < 3000) begin
            tick();
            k++;
        end
        check("t3_see_word2", {31'd0, (dig_valid && dig_index == 3'd2)}, 1);
        tick();
        dig_ready = 1'b0;
        k = 0;
        while (!dig_valid && k < 50) begin
            tick();
            k++;
        end
        rn = rd_n;
        for (int i = 0; i < 7; i++) begin
            check("t3_hold_valid", {31'd0, dig_valid}, 1);
            check("t3_hold_data", dig_data, 32'hD16E_0013);
            check("t3_hold_idx", {29'd0, dig_index}, 3);
            tick();
        end
        check("t3_no_read", rd_n - rn, 0);
        dig_ready = 1'b1;
        r = cyc;
        wait_done("t3_done", db + 8);
        check("t3_next_addr", {27'd0, rd_addr[rn]}, 32'h14);
        check("t3_next_cyc", rd_cyc[rn], r + 1);
        check_digest("t3", db);

        // Reset during GAP1, then a full transaction
        wb = wr_n;
        send(32'h0F0F_0F0F, 6'd32, 1'b1, a);
        tick();
        reset = 1'b1;
        #1;
        check("t4_msg_ready", {31'd0, msg_ready}, 0);
        check("t4_busy", {31'd0, busy}, 0);
        check("t4_strobes", {29'd0, avm_write, avm_read, avm_chipselect}, 0);
        check("t4_addr", {27'd0, avm_address}, 0);
        check("t4_wdata", avm_writedata, 0);
        check("t4_be", {28'd0, avm_byteenable}, 0);
        check("t4_dig", {dig_data[30:0], dig_valid}, 0);
        check("t4_dig_idx", {28'd0, dig_index, dig_last}, 0);
        tick();
        tick();
        reset = 1'b0;
        check("t4_nwr_abort", wr_n - wb, 1);
        ready_after = 2;
        wb = wr_n; db = dg_n;
        send(32'h1234_5678, 6'd24, 1'b1, a);
        wait_done("t4_done", db + 8);
        check("t4_nwr", wr_n - wb, 3);
        check("t4_len", wr_data[wb], 32'h8000_0018);
        check("t4_dat", wr_data[wb+1], 32'h1234_5678);
        check_digest("t4", db);

        // Oversized bit count and empty final word
        ready_after = 1;
        wb = wr_n; db = dg_n;
        send(32'hDEAD_BEEF, 6'd40, 1'b0, a);
        send(32'h0000_0000, 6'd0, 1'b1, a2);
        wait_done("t6_done", db + 8);
        check("t6_len40", wr_data[wb], 32'h0000_0020);
        check("t6_len_empty", wr_data[wb+2], 32'h8000_0000);

`ifdef KECCAK_SEQ_TIMEOUT_EN
        // Poll timeout with hash_ready never set
        ready_after = 0;
        wb = wr_n; rb = rd_n; db = dg_n;
        send(32'h8000_0000, 6'd1, 1'b1, a);
        wait_done("t5_done", db);
        check("t5_nrd", rd_n - rb, PL);
        for (int i = 0; i < PL; i++) check("t5_poll_addr", {27'd0, rd_addr[rb+i]}, 32'h4);
        check("t5_nwr", wr_n - wb, 2);
        check("t5_timeout", {31'd0, timeout_err}, 1);
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_msg_ready", {31'd0, msg_ready}, 1);
        check("t5_no_digest", dg_n - db, 0);
`else
        check("t5_timeout_tied", {31'd0, timeout_err}, 0);
`endif

        check("bus_gap", gap_err, 0);
        check("bus_cs_be", cs_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
